// File: rtl/instruction_fetch_if.sv
// Instruction-memory bus between the IF stage and instruction memory.
//   imemReq   : fetch request, driven by the fetch stage
//   imemAddr  : fetch address, driven by the fetch stage
//   imemReady : memory has data for imemAddr this cycle
//   imemData  : instruction word, valid when imemReady=1
// master = fetch stage side, slave = memory side.
interface instruction_fetch_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;

  modport master (output imemReq, imemAddr, input imemReady, imemData);
  modport slave  (input imemReq, imemAddr, output imemReady, imemData);
endinterface

// File: rtl/instruction_fetch.sv
// IF stage of the mips32 pipeline. Holds the PC, requests instructions over
// the imem bus and feeds the IF_ID register. A one-entry skid buffer absorbs
// a word that returns while the hazard unit stalls; redirects flush the stage.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   stall      : IF_ID cannot accept, hold outputs
//   redirect   : taken branch/jump, flush and refetch from redirectPc
//   redirectPc : redirect target (bits [1:0] ignored)
//   bus        : instruction-memory bus (master side)
//   pcOut      : fetched address + 4
//   instOut    : fetched instruction (NOP_INST on bubbles)
//   validOut   : pcOut/instOut carry a real instruction
//
// state | meaning
// IDLE  | first cycle after reset, no request
// FETCH | request outstanding for pc
// HOLD  | skid buffer full, waiting for stall to drop
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [31:0]                redirectPc,
  instruction_fetch_if.master        bus,
  output logic [31:0]                pcOut,
  output logic [31:0]                instOut,
  output logic                       validOut
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic [31:0] pc_next;

  // Wraps modulo 2^32 naturally.
  assign pc_next = pc + 32'd4;

  // Decoded from registered state only; no input reaches the memory bus.
  assign bus.imemReq  = (state == FETCH);
  assign bus.imemAddr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      skid_pc   <= 32'h0;
      skid_inst <= NOP_INST;
      pcOut     <= 32'h0;
      instOut   <= NOP_INST;
      validOut  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Redirect is deliberately ignored here.
          state <= FETCH;
        end
        FETCH, HOLD: begin
          if (redirect) begin
            // Any word returning this cycle belongs to the old path and is dropped.
            pc        <= {redirectPc[31:2], 2'b00};
            skid_pc   <= 32'h0;
            skid_inst <= NOP_INST;
            instOut   <= NOP_INST;
            validOut  <= 1'b0;
            state     <= FETCH;
          end else if (state == FETCH) begin
            if (bus.imemReady) begin
              pc <= pc_next;
              if (stall) begin
                skid_pc   <= pc_next;
                skid_inst <= bus.imemData;
                state     <= HOLD;
              end else begin
                pcOut    <= pc_next;
                instOut  <= bus.imemData;
                validOut <= 1'b1;
              end
            end else if (!stall) begin
              instOut  <= NOP_INST;
              validOut <= 1'b0;
            end
          end else if (!stall) begin
            pcOut     <= skid_pc;
            instOut   <= skid_inst;
            validOut  <= 1'b1;
            skid_pc   <= 32'h0;
            skid_inst <= NOP_INST;
            state     <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
IF stage of the mips32 pipeline. Holds the program counter, issues instruction-memory requests, and presents pcOut/instOut/validOut directly to the IF_ID pipeline register. It absorbs memory wait states and hazard-unit stalls through a one-entry skid buffer. Branch and jump redirects from later stages flush it.

Parameters:
RESET_PC, 32'h00000000, PC value loaded at reset
NOP_INST, 32'h00000000, instruction word driven on bubbles (sll $0,$0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
stall  input  1  hazard unit: IF_ID cannot accept; hold outputs
redirect  input  1  taken branch/jump: flush and refetch
redirectPc  input  32  target address for redirect
imemReq  output  1  instruction memory request
imemAddr  output  32  fetch address (always current pc)
imemReady  input  1  memory data valid this cycle for imemAddr
imemData  input  32  instruction word, valid when imemReady=1
pcOut  output  32  fetched address + 4, to IF_ID
instOut  output  32  fetched instruction, to IF_ID
validOut  output  1  pcOut/instOut hold a real instruction

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=IDLE, skid buffer empty, pcOut=0, instOut=NOP_INST, validOut=0, imemReq=0.
- States: IDLE, FETCH, HOLD. imemReq=1 only in FETCH. imemAddr=pc in all states.
- IDLE -> FETCH on the first rising edge after reset release. No other action.
- FETCH, imemReady=1, stall=0: output regs take pcOut=pc+4, instOut=imemData, validOut=1. pc<=pc+4. Stay in FETCH.
- FETCH, imemReady=1, stall=1: skid buffer takes {pc+4, imemData}. Output regs hold. pc<=pc+4. Go to HOLD.
- FETCH, imemReady=0, stall=0: validOut<=0 and instOut<=NOP_INST (bubble). pcOut holds.
- FETCH, imemReady=0, stall=1: output regs hold.
- HOLD: imemReq=0. While stall=1, everything holds. When stall=0: output regs take skid contents with validOut=1, skid is emptied, go to FETCH.
- Memory contract: the address may change while imemReq=1. Data returned in the imemReady cycle belongs to the imemAddr of that same cycle.
- Redirect has the highest priority and overrides stall and imemReady in any state except IDLE:
  - pc<=redirectPc with bits[1:0] forced to 0.
  - Skid buffer is discarded.
  - validOut<=0, instOut<=NOP_INST. pcOut holds.
  - Next state is FETCH.
  - Memory data arriving in the redirect cycle is dropped.
- Redirect in IDLE is ignored.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 32'h00000000). No overflow flag.
- Zero-wait memory (imemReady tied to 1): one instruction per cycle. The first validOut=1 appears after the 2nd rising edge following reset release.
- Reset asserted mid-operation: all state clears immediately, asynchronously. An in-flight request is abandoned because imemReq drops at once.
- All outputs except imemReq and imemAddr are registered. imemReq and imemAddr are decoded from registered state only, with no combinational path from any input.

Test Plan:
1. Reset release, imemReady=1, memory returns word = address: after edge 2, pcOut=4, instOut=32'h0, validOut=1; after edge 3, pcOut=8, instOut=32'h4.
2. imemReady low for 3 cycles on the fetch of addr 8: validOut=0 and instOut=NOP for those cycles, imemAddr stays 8; when ready, pcOut=12.
3. stall=1 in the cycle data for addr 12 arrives, held for 4 cycles: outputs frozen, imemReq=0 (HOLD); after stall drops, pcOut=16, instOut=data@12, next imemAddr=16, no instruction lost or duplicated.
4. redirect=1 with redirectPc=32'h00000103 while in HOLD with stall=1: validOut=0, skid discarded, next imemAddr=32'h00000100, next valid pcOut=32'h00000104.
5. redirect=1 in the same cycle as imemReady=1 for addr 20: data is dropped, validOut=0, next fetch from redirectPc.
6. Redirect to 32'hFFFFFFFC, then 2 fetches: pcOut=32'h00000000 and then 32'h00000004; rst pulsed low mid-fetch: outputs return to reset values immediately, with no clock edge needed.
